// File: rtl/msg_len_accum.sv
// rtl/msg_len_accum.sv - per-message byte length accumulator with completed-length FIFO
//
// Sums per-beat byte counts into a whole-message length, closes the message on
// the last beat and queues {length, saturated} entries for a valid/ready consumer.
//
// Ports:
//   clk           clock, all logic on rising edge
//   rst           asynchronous active-low reset
//   beat_valid    beat strobe; beat_last/beat_len valid this cycle
//   beat_last     beat closes the open message
//   beat_len      bytes carried by this beat
//   m_len_tvalid  FIFO head valid
//   m_len_tready  consumer accepts head
//   m_len_tdata   completed message length (registered from FIFO storage)
//   m_len_tsat    head entry's length saturated
//   in_msg        a non-last beat has been accumulated for the open message
//   fifo_level    entries held
//   drop_cnt      messages dropped on a full FIFO, saturating
//   sat_err       sticky: some message saturated
//   clr_err       synchronous clear of sat_err and drop_cnt
module msg_len_accum #(
    parameter int NUM_COUNT_BITS = 16,
    parameter int LEN_WIDTH      = 32,
    parameter int FIFO_DEPTH     = 4,
    parameter int DROP_CNT_BITS  = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          beat_valid,
    input  logic                          beat_last,
    input  logic [NUM_COUNT_BITS-1:0]     beat_len,
    output logic                          m_len_tvalid,
    input  logic                          m_len_tready,
    output logic [LEN_WIDTH-1:0]          m_len_tdata,
    output logic                          m_len_tsat,
    output logic                          in_msg,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [DROP_CNT_BITS-1:0]      drop_cnt,
    output logic                          sat_err,
    input  logic                          clr_err
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [PW:0]              LVL_FULL = (PW+1)'(FIFO_DEPTH);
    localparam logic [PW:0]              LVL_ONE  = (PW+1)'(1);
    localparam logic [PW-1:0]            PTR_ONE  = PW'(1);
    localparam logic [DROP_CNT_BITS-1:0] DROP_ONE = DROP_CNT_BITS'(1);

    logic [LEN_WIDTH-1:0] acc;
    logic                 acc_sat;

    logic [LEN_WIDTH-1:0] mem_len [FIFO_DEPTH];
    logic                 mem_sat [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_ptr;

    logic [LEN_WIDTH:0]   sum_wide;
    logic                 sum_sat;
    logic [LEN_WIDTH-1:0] sum_len;
    logic                 push;
    logic                 pop;
    logic                 push_ok;
    logic                 drop;
    logic [PW:0]          level_next;
    logic [PW-1:0]        head_ptr_next;
    logic                 bypass;
    logic [LEN_WIDTH-1:0] head_len_next;
    logic                 head_sat_next;

    always_comb begin
        sum_wide = {1'b0, acc} + (LEN_WIDTH+1)'(beat_len);
        // Once a message has saturated it stays pinned at all-ones until it closes.
        sum_sat  = sum_wide[LEN_WIDTH] | acc_sat;
        sum_len  = sum_sat ? '1 : sum_wide[LEN_WIDTH-1:0];
    end

    assign m_len_tvalid = (fifo_level != '0);

    always_comb begin
        push    = beat_valid & beat_last;
        pop     = m_len_tvalid & m_len_tready;
        // A pop frees a slot in the same cycle, so a full FIFO can still accept.
        push_ok = push & ((fifo_level < LVL_FULL) | pop);
        drop    = push & ~push_ok;

        level_next = fifo_level;
        case ({push_ok, pop})
            2'b10:   level_next = fifo_level + LVL_ONE;
            2'b01:   level_next = fifo_level - LVL_ONE;
            default: level_next = fifo_level;
        endcase

        head_ptr_next = pop ? rd_ptr + PTR_ONE : rd_ptr;
        // The entry being written becomes the head only when nothing older remains;
        // storage is not yet written then, so forward it directly.
        bypass        = push_ok & (head_ptr_next == wr_ptr);
        head_len_next = bypass ? sum_len : mem_len[head_ptr_next];
        head_sat_next = bypass ? sum_sat : mem_sat[head_ptr_next];
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_len[wr_ptr] <= sum_len;
            mem_sat[wr_ptr] <= sum_sat;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc     <= '0;
            acc_sat <= 1'b0;
            in_msg  <= 1'b0;
        end else if (beat_valid) begin
            if (beat_last) begin
                acc     <= '0;
                acc_sat <= 1'b0;
                in_msg  <= 1'b0;
            end else begin
                acc     <= sum_len;
                acc_sat <= sum_sat;
                in_msg  <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_level  <= '0;
            m_len_tdata <= '0;
            m_len_tsat  <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            fifo_level <= level_next;
            // Output holds its last value when the FIFO goes empty.
            if (level_next != '0) begin
                m_len_tdata <= head_len_next;
                m_len_tsat  <= head_sat_next;
            end
        end
    end

    // Set/increment takes priority over a simultaneous clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop_cnt <= '0;
            sat_err  <= 1'b0;
        end else begin
            if (drop) begin
                if (clr_err) begin
                    drop_cnt <= DROP_ONE;
                end else if (drop_cnt != '1) begin
                    drop_cnt <= drop_cnt + DROP_ONE;
                end
            end else if (clr_err) begin
                drop_cnt <= '0;
            end

            if (push & sum_sat) begin
                sat_err <= 1'b1;
            end else if (clr_err) begin
                sat_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_msg_len_accum.sv
// tb/tb_msg_len_accum.sv - self-checking bench for msg_len_accum
module tb_msg_len_accum;

    localparam int NCB    = 16;
    localparam int LW     = 16;
    localparam int DEPTH  = 4;
    localparam int DCB    = 8;
    localparam int unsigned MAXLEN  = (1 << LW) - 1;
    localparam int          DROPMAX = (1 << DCB) - 1;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           beat_valid = 1'b0;
    logic           beat_last = 1'b0;
    logic [NCB-1:0] beat_len = '0;
    logic           m_len_tvalid;
    logic           m_len_tready = 1'b0;
    logic [LW-1:0]  m_len_tdata;
    logic           m_len_tsat;
    logic           in_msg;
    logic [2:0]     fifo_level;
    logic [DCB-1:0] drop_cnt;
    logic           sat_err;
    logic           clr_err = 1'b0;

    msg_len_accum #(
        .NUM_COUNT_BITS(NCB),
        .LEN_WIDTH(LW),
        .FIFO_DEPTH(DEPTH),
        .DROP_CNT_BITS(DCB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .beat_valid(beat_valid),
        .beat_last(beat_last),
        .beat_len(beat_len),
        .m_len_tvalid(m_len_tvalid),
        .m_len_tready(m_len_tready),
        .m_len_tdata(m_len_tdata),
        .m_len_tsat(m_len_tsat),
        .in_msg(in_msg),
        .fifo_level(fifo_level),
        .drop_cnt(drop_cnt),
        .sat_err(sat_err),
        .clr_err(clr_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int unsigned q_len[$];
    bit          q_sat[$];
    int unsigned m_acc;
    bit          m_sat;
    bit          m_in;
    bit          m_serr;
    int          m_drop;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        q_len.delete();
        q_sat.delete();
        m_acc  = 0;
        m_sat  = 0;
        m_in   = 0;
        m_serr = 0;
        m_drop = 0;
    endtask

    // Reference behaviour for one clock edge, using the inputs present at that edge.
    task automatic model_edge(input bit v, input bit l, input int unsigned len,
                              input bit rdy, input bit clr);
        bit          pop;
        bit          accept;
        bit          psat;
        int unsigned s;
        int unsigned plen;
        pop    = (q_len.size() != 0) && rdy;
        accept = 0;
        psat   = 0;
        plen   = 0;
        if (clr) begin
            m_drop = 0;
            m_serr = 0;
        end
        if (v) begin
            s    = m_acc + len;
            psat = m_sat || (s > MAXLEN);
            plen = psat ? MAXLEN : s;
            if (!l) begin
                m_acc = plen;
                m_sat = psat;
                m_in  = 1;
            end else begin
                accept = (q_len.size() < DEPTH) || pop;
                if (!accept) m_drop = (m_drop < DROPMAX) ? m_drop + 1 : DROPMAX;
                if (psat) m_serr = 1;
                m_acc = 0;
                m_sat = 0;
                m_in  = 0;
            end
        end
        if (pop) begin
            void'(q_len.pop_front());
            void'(q_sat.pop_front());
        end
        if (accept) begin
            q_len.push_back(plen);
            q_sat.push_back(psat);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".tvalid"}, 32'(m_len_tvalid), 32'(q_len.size() != 0));
        chk({tag, ".level"},  32'(fifo_level),   q_len.size());
        chk({tag, ".drop"},   32'(drop_cnt),     m_drop);
        chk({tag, ".saterr"}, 32'(sat_err),      32'(m_serr));
        chk({tag, ".inmsg"},  32'(in_msg),       32'(m_in));
        if (q_len.size() != 0) begin
            chk({tag, ".tdata"}, 32'(m_len_tdata), q_len[0]);
            chk({tag, ".tsat"},  32'(m_len_tsat),  32'(q_sat[0]));
        end
    endtask

    task automatic step(input bit v, input bit l, input int unsigned len,
                        input bit rdy, input bit clr, input string tag);
        beat_valid   = v;
        beat_last    = l;
        beat_len     = NCB'(len);
        m_len_tready = rdy;
        clr_err      = clr;
        @(posedge clk);
        model_edge(v, l, len, rdy, clr);
        #1;
        check_model(tag);
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_model("reset");
        chk("reset.tdata", 32'(m_len_tdata), 0);
        chk("reset.tsat",  32'(m_len_tsat),  0);
        rst = 1'b1;

        // 8 + 8 + 3 = 19
        step(1, 0, 8, 0, 0, "m19.b0");
        step(1, 0, 8, 0, 0, "m19.b1");
        step(1, 1, 3, 0, 0, "m19.last");
        chk("m19.tdata", 32'(m_len_tdata), 19);
        chk("m19.valid", 32'(m_len_tvalid), 1);
        step(0, 0, 0, 1, 0, "m19.pop");
        chk("m19.popvalid", 32'(m_len_tvalid), 0);
        chk("m19.poplevel", 32'(fifo_level), 0);

        // Five messages into a stalled FIFO: fifth is dropped
        for (int k = 1; k <= 5; k++) step(1, 1, k, 0, 0, "fill5");
        chk("fill5.drop",  32'(drop_cnt),   1);
        chk("fill5.level", 32'(fifo_level), 4);
        for (int k = 1; k <= 4; k++) begin
            step(0, 0, 0, 0, 0, "stall0");
            step(0, 0, 0, 0, 0, "stall1");
            chk("stall.tdata", 32'(m_len_tdata), k);
            step(0, 0, 0, 1, 0, "drain5");
        end

        // Full FIFO, push and pop in the same cycle
        for (int k = 10; k <= 13; k++) step(1, 1, k, 0, 0, "fill4");
        step(1, 1, 7, 1, 0, "pushpop");
        chk("pushpop.level", 32'(fifo_level), 4);
        chk("pushpop.drop",  32'(drop_cnt),   1);
        for (int k = 0; k < 3; k++) step(0, 0, 0, 1, 0, "drainpp");
        chk("pushpop.last", 32'(m_len_tdata), 7);
        step(0, 0, 0, 1, 0, "drainpp");

        // Saturation
        step(1, 0, 'hFFF0, 0, 0, "sat.b0");
        step(1, 0, 'h0020, 0, 0, "sat.b1");
        step(1, 1, 'h0001, 0, 0, "sat.last");
        chk("sat.tdata",  32'(m_len_tdata), 'hFFFF);
        chk("sat.tsat",   32'(m_len_tsat),  1);
        chk("sat.saterr", 32'(sat_err),     1);
        step(1, 0, 2, 1, 0, "after.b0");
        step(1, 1, 2, 0, 0, "after.last");
        chk("after.tdata", 32'(m_len_tdata), 4);
        chk("after.tsat",  32'(m_len_tsat),  0);
        step(0, 0, 0, 1, 0, "after.pop");

        // Asynchronous reset mid-message with a non-empty FIFO
        step(1, 1, 20, 0, 0, "pre.m0");
        step(1, 1, 21, 0, 0, "pre.m1");
        step(1, 0, 4, 0, 0, "pre.b0");
        step(1, 0, 8, 0, 0, "pre.b1");
        chk("pre.inmsg", 32'(in_msg), 1);
        beat_valid = 0; beat_last = 0; beat_len = '0; m_len_tready = 0;
        rst = 1'b0;
        #1;
        model_reset();
        chk("arst.tvalid", 32'(m_len_tvalid), 0);
        chk("arst.tdata",  32'(m_len_tdata),  0);
        chk("arst.level",  32'(fifo_level),   0);
        chk("arst.inmsg",  32'(in_msg),       0);
        chk("arst.saterr", 32'(sat_err),      0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        step(1, 1, 5, 0, 0, "post.last");
        chk("post.tdata", 32'(m_len_tdata), 5);
        step(0, 0, 0, 1, 0, "post.pop");

        // Drop counter saturation and clear priority
        for (int k = 0; k < 4; k++) step(1, 1, 1, 0, 0, "dfill");
        for (int k = 0; k < 260; k++) step(1, 1, 3, 0, 0, "dsat");
        chk("dsat.drop", 32'(drop_cnt), 255);
        step(1, 1, 3, 0, 1, "dclr.drop");
        chk("dclr.drop", 32'(drop_cnt), 1);
        step(0, 0, 0, 0, 1, "dclr.alone");
        chk("dclr.zero", 32'(drop_cnt), 0);
        for (int k = 0; k < 4; k++) step(0, 0, 0, 1, 0, "ddrain");

        // Randomized traffic against the reference model
        for (int k = 0; k < 400; k++) begin
            bit          v;
            bit          l;
            bit          rdy;
            bit          clr;
            int unsigned len;
            v   = ($urandom % 4) != 0;
            l   = ($urandom % 3) == 0;
            len = (($urandom % 16) == 0) ? ($urandom % 65536) : ($urandom % 64);
            rdy = ($urandom % 2) == 1;
            clr = ($urandom % 32) == 0;
            step(v, l, len, rdy, clr, "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/msg_len_accum.md
Name: msg_len_accum

Overview:
- Downstream of the per-beat byte counter.
- Sums per-beat byte counts into a whole-message byte length, closing each message on the last beat.
- Queues completed lengths in a small FIFO and presents them on a valid/ready length stream to the descriptor/statistics logic.
- Flags accumulator saturation and FIFO-full drops.

Parameters:
NUM_COUNT_BITS, 16, width of incoming per-beat byte count
LEN_WIDTH, 32, width of accumulated message length; must be >= NUM_COUNT_BITS
FIFO_DEPTH, 4, completed-length FIFO entries; power of 2, >= 2
DROP_CNT_BITS, 8, width of dropped-message counter

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  asynchronous active-low reset
beat_valid  input  1  one-cycle strobe: beat_len/beat_last valid this cycle
beat_last  input  1  beat closes the current message (qualified by beat_valid)
beat_len  input  NUM_COUNT_BITS  bytes carried by this beat
m_len_tvalid  output  1  FIFO head valid
m_len_tready  input  1  consumer accepts head
m_len_tdata  output  LEN_WIDTH  completed message length in bytes
m_len_tsat  output  1  head entry's length saturated
in_msg  output  1  at least one non-last beat accumulated for the open message
fifo_level  output  $clog2(FIFO_DEPTH)+1  entries held
drop_cnt  output  DROP_CNT_BITS  messages dropped on full FIFO, saturating
sat_err  output  1  sticky: any message saturated
clr_err  input  1  synchronous clear of sat_err and drop_cnt

Behaviour:
- Reset (rst low, async): accumulator 0, open-message sat flag 0, FIFO empty, m_len_tvalid 0, m_len_tdata 0, m_len_tsat 0, in_msg 0, fifo_level 0, drop_cnt 0, sat_err 0.
- sum = acc + zero-extended beat_len, computed LEN_WIDTH+1 wide. If bit LEN_WIDTH is set, or the open-message sat flag is already set, the result is all-ones and sat=1.
- beat_valid & !beat_last: acc <= sum (saturated); in_msg <= 1; sat flag updated.
- beat_valid & beat_last: push {sum, sat} into the FIFO; acc <= 0; sat flag <= 0; in_msg <= 0.
  - Zero-length beats are legal. A single last beat with beat_len=0 pushes length 0.
- beat_valid low: accumulator holds. There is no timeout.
- Push acceptance: accepted if fifo_level < FIFO_DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the entry is discarded and drop_cnt increments, saturating at all-ones.
  - On a drop the accumulator still clears.
- sat_err sets on any pushed or dropped entry with sat=1.
- clr_err clears sat_err and drop_cnt. An increment or set in the same cycle as clr_err wins; the result is 1, not 0.
- Pop: m_len_tvalid & m_len_tready advances the read pointer.
  - m_len_tvalid = (fifo_level != 0).
  - m_len_tdata and m_len_tsat are held stable while valid and not ready.
- Output data is registered from FIFO storage. m_len_tdata holds its last value when empty; benches must not check it then.
- Latency: beat_last at edge N into an empty FIFO gives m_len_tvalid=1 and m_len_tdata valid after edge N, visible in cycle N+1. No combinational path from any beat_* input to any output.
- Simultaneous push and pop: fifo_level unchanged; ordering preserved.
- Simultaneous push and pop while empty: cannot occur, because valid=0 so no pop.
- Pointers: log2(FIFO_DEPTH) bits, wrap naturally. fifo_level is maintained separately: +1 on push only, -1 on pop only.
- Reset mid-message or with a non-empty FIFO: all state returns to the reset values in the same cycle. No partial message survives.

Test Plan:
- Reset, then beats 8,8,3 (last on 3) -> cycle after the last beat: m_len_tvalid=1, tdata=19, tsat=0, fifo_level=1. Pop with ready=1 -> valid=0, level=0.
- m_len_tready=0. Five single-beat messages of 1,2,3,4,5 -> FIFO holds 1,2,3,4; drop_cnt=1. Drain -> outputs 1,2,3,4 in order, with tdata stable during the 2-cycle stall before each pop.
- FIFO full with ready=1 and beat_last(len 7) in the same cycle -> push accepted, level stays 4, drop_cnt unchanged, 7 appears last.
- LEN_WIDTH=16, NUM_COUNT_BITS=16: beats 0xFFF0, 0x0020, last 0x0001 -> tdata=0xFFFF, tsat=1, sat_err=1. Next message 2,last 2 -> tdata=4, tsat=0.
- Mid-message (acc=12, in_msg=1) and FIFO level 2: assert rst low for 1 cycle -> all outputs 0 immediately. Then last beat 5 -> tdata=5.
- Drive drop_cnt to 255 with more drops -> stays 255. clr_err same cycle as a drop -> drop_cnt=1. clr_err alone -> 0.
